// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared encodings and defaults for the fetch next-PC sequencer.
// Redirect classes are ordered so that a numeric compare gives their priority.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

package fetch_redirect_ctrl_pkg;

  localparam int WORD_W = `WORD_WIDTH;
  localparam logic [31:0] PC_BASE_DEF = 32'h0000_3000;

  typedef enum logic [1:0] {
    RC_NONE   = 2'd0,
    RC_JUMP   = 2'd1,
    RC_BRANCH = 2'd2,
    RC_TRAP   = 2'd3
  } redir_class_t;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  // Branch and trap redirects also kill the instruction already in execute.
  function automatic logic class_flushes_e(input redir_class_t c);
    return (c == RC_BRANCH) || (c == RC_TRAP);
  endfunction

endpackage

// File: rtl/fetch_redirect_ctrl_if.sv
// Fetch-stage control bundle: redirect requests and stall state in,
// next PC, stall, flushes and the stall counter out.
interface fetch_redirect_ctrl_if #(
  parameter int WIDTH     = fetch_redirect_ctrl_pkg::WORD_W,
  parameter int CNT_WIDTH = 32
);
  logic [WIDTH-1:0]     pc;
  logic                 icache_busy;
  logic                 hazard_stall;
  logic                 jump_valid;
  logic [WIDTH-1:0]     jump_target;
  logic                 branch_valid;
  logic [WIDTH-1:0]     branch_target;
  logic                 trap_valid;
  logic [WIDTH-1:0]     trap_target;
  logic [WIDTH-1:0]     npc;
  logic                 stallF;
  logic                 flushD;
  logic                 flushE;
  logic                 redirect_pending;
  logic [CNT_WIDTH-1:0] stall_cycles;

  modport master (
    output pc, icache_busy, hazard_stall, jump_valid, jump_target,
           branch_valid, branch_target, trap_valid, trap_target,
    input  npc, stallF, flushD, flushE, redirect_pending, stall_cycles
  );

  modport slave (
    input  pc, icache_busy, hazard_stall, jump_valid, jump_target,
           branch_valid, branch_target, trap_valid, trap_target,
    output npc, stallF, flushD, flushE, redirect_pending, stall_cycles
  );
endinterface

// File: rtl/fetch_redirect_ctrl_redirect_prio_sel.sv
// Combinational priority pick among this cycle's redirect requests:
// trap over branch over jump.
module redirect_prio_sel
  import fetch_redirect_ctrl_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             jump_valid,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             branch_valid,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             trap_valid,
  input  logic [WIDTH-1:0] trap_target,
  output redir_class_t     req_class,
  output logic [WIDTH-1:0] req_target
);

  always_comb begin
    // NOTE: defaults are assigned first so every path writes both outputs and no latch is inferred.
    req_class  = RC_NONE;
    req_target = '0;
    if (trap_valid) begin
      req_class  = RC_TRAP;
      req_target = trap_target;
    end else if (branch_valid) begin
      req_class  = RC_BRANCH;
      req_target = branch_target;
    end else if (jump_valid) begin
      req_class  = RC_JUMP;
      req_target = jump_target;
    end
  end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Next-PC sequencer: picks sequential/jump/branch/trap npc, holds a redirect
// that arrives while fetch is busy, and drives flushes and a stall counter.
module fetch_redirect_ctrl
  import fetch_redirect_ctrl_pkg::*;
#(
  parameter int               WIDTH       = WORD_W,
  parameter logic [WIDTH-1:0] PC_BASE     = WIDTH'(PC_BASE_DEF),
  parameter int               INSTR_BYTES = 4,
  parameter int               CNT_WIDTH   = 32
) (
  input logic                  clk,
  input logic                  rst,
  fetch_redirect_ctrl_if.slave bus
);

  state_t               state;
  redir_class_t         pend_class;
  logic [WIDTH-1:0]     pend_tgt;
  logic [CNT_WIDTH-1:0] stall_cnt;

  redir_class_t     new_class;
  logic [WIDTH-1:0] new_tgt;
  logic             overwrite;
  logic [WIDTH-1:0] npc;
  logic             stall_f;
  logic             flush_d;
  logic             flush_e;

  redirect_prio_sel #(.WIDTH(WIDTH)) u_prio (
    .jump_valid    (bus.jump_valid),
    .jump_target   (bus.jump_target),
    .branch_valid  (bus.branch_valid),
    .branch_target (bus.branch_target),
    .trap_valid    (bus.trap_valid),
    .trap_target   (bus.trap_target),
    .req_class     (new_class),
    .req_target    (new_tgt)
  );

  // Only a strictly older-path (higher class) request may replace a held one.
  assign overwrite = (state == ST_PENDING) && (new_class > pend_class);

  always_comb begin
    npc     = bus.pc + WIDTH'(INSTR_BYTES);
    stall_f = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    if (rst) begin
      npc = PC_BASE;
    end else if (state == ST_IDLE) begin
      if (new_class != RC_NONE) begin
        flush_d = 1'b1;
        flush_e = class_flushes_e(new_class);
        stall_f = bus.icache_busy;
        npc     = bus.icache_busy ? bus.pc : new_tgt;
      end else begin
        stall_f = bus.icache_busy | bus.hazard_stall;
      end
    end else begin
      // Younger path is being flushed, so a decode hazard cannot hold the PC here.
      stall_f = bus.icache_busy;
      npc     = overwrite ? new_tgt : pend_tgt;
      if (overwrite) begin
        flush_d = 1'b1;
        flush_e = class_flushes_e(new_class);
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state      <= ST_IDLE;
      pend_class <= RC_NONE;
      pend_tgt   <= PC_BASE;
      stall_cnt  <= '0;
    end else begin
      if (stall_f && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_WIDTH'(1);
      case (state)
        ST_IDLE: begin
          if ((new_class != RC_NONE) && bus.icache_busy) begin
            state      <= ST_PENDING;
            pend_class <= new_class;
            pend_tgt   <= new_tgt;
          end
        end
        default: begin
          if (!bus.icache_busy) begin
            state      <= ST_IDLE;
            pend_class <= RC_NONE;
          end else if (overwrite) begin
            pend_class <= new_class;
            pend_tgt   <= new_tgt;
          end
        end
      endcase
    end
  end

  assign bus.npc              = npc;
  assign bus.stallF           = stall_f;
  assign bus.flushD           = flush_d;
  assign bus.flushE           = flush_e;
  assign bus.redirect_pending = (state == ST_PENDING);
  assign bus.stall_cycles     = stall_cnt;

endmodule
